// File: rtl/fsm_stim_sequencer_if.sv
// Link between the stimulus sequencer and the FSM under test: the sequencer
// drives the command code, the FSM returns its output code.
interface fsm_stim_sequencer_if #(
  parameter int INPUT_SIZE  = 3,
  parameter int OUTPUT_SIZE = 6
);
  // No valid/ready pair: input_signal is a registered level that the FSM
  // samples every cycle, and output_signal is sampled by the sequencer only
  // on the final cycle of each program step.
  logic [INPUT_SIZE-1:0]  input_signal;
  logic [OUTPUT_SIZE-1:0] output_signal;

  modport master (output input_signal, input output_signal);
  modport slave  (input input_signal, output output_signal);
endinterface

// File: rtl/fsm_stim_sequencer.sv
// Replays a programmed list of {last, hold, expected, cmd} steps into an FSM
// under test and counts steps whose final-cycle output differs from expected.
module fsm_stim_sequencer #(
  parameter int INPUT_SIZE  = 3,
  parameter int OUTPUT_SIZE = 6,
  parameter int HOLD_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int ERR_W       = 8,
  localparam int PW         = 1 + HOLD_W + OUTPUT_SIZE + INPUT_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [PW-1:0]             prog_data,
  input  logic                      start,
  fsm_stim_sequencer_if.master      fsm,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [ADDR_W-1:0]         err_step,
  output logic [1:0]                state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [PW-1:0]          mem [DEPTH];
  logic [ADDR_W-1:0]      ptr;
  logic [HOLD_W-1:0]      cnt;
  logic [OUTPUT_SIZE-1:0] cur_exp;
  logic                   cur_last;
  logic                   mismatch;
  logic [ERR_W-1:0]       err_next;
  logic                   idle_like;

  assign state_dbg = state;
  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    mismatch = 1'b0;
    err_next = err_count;
    mismatch = (fsm.output_signal != cur_exp);
    if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_next = err_count + 1'b1;
  end

  // Program memory survives reset so a run can be restarted without reload.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      fsm.input_signal <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      err_step         <= '0;
      ptr              <= '0;
      cnt              <= '0;
      cur_exp          <= '0;
      cur_last         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_FETCH;
            ptr       <= '0;
            err_count <= '0;
            err_step  <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          fsm.input_signal <= mem[ptr][INPUT_SIZE-1:0];
          cur_exp          <= mem[ptr][INPUT_SIZE +: OUTPUT_SIZE];
          cnt              <= mem[ptr][INPUT_SIZE+OUTPUT_SIZE +: HOLD_W];
          cur_last         <= mem[ptr][PW-1];
          state            <= S_RUN;
        end
        S_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_count <= err_next;
            // err_count never returns to zero once set, so zero means "no error yet".
            if (mismatch && (err_count == '0))
              err_step <= ptr;
            if (cur_last || (&ptr)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              ptr   <= ptr + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
